// File: rtl/fc_argmax.sv
// Serial argmax over a snapshot of the FC layer's signed Q8.8 score vector.
// The winning index and score are held under a valid/ack handshake until the consumer accepts them.
module fc_argmax #(
  parameter int OC    = 10,
  parameter int W     = 16,
  parameter int IDX_W = $clog2(OC > 1 ? OC : 2)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scores_valid,
  input  logic signed [W-1:0] scores [0:OC-1],
  input  logic                result_ack,
  output logic [IDX_W-1:0]    class_idx,
  output logic [W-1:0]        max_score,
  output logic                result_valid,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCAN     = 2'd1,
    DONE     = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OC - 1);

  state_t              state, state_n;
  logic signed [W-1:0] snap [0:OC-1];
  logic signed [W-1:0] best;
  logic [IDX_W-1:0]    best_idx;
  logic [IDX_W-1:0]    i;

  // Winner after folding in the current snapshot entry; strict > keeps the lowest index on ties.
  logic                take;
  logic signed [W-1:0] win_val;
  logic [IDX_W-1:0]    win_idx;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    take    = 1'b0;
    win_val = best;
    win_idx = best_idx;
    if (state == SCAN && snap[i] > best) begin
      take    = 1'b1;
      win_val = snap[i];
      win_idx = i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (scores_valid) state_n = (OC == 1) ? DONE : SCAN;
      SCAN:     if (i == LAST_IDX) state_n = DONE;
      DONE:     if (result_ack) state_n = scores_valid ? WAIT_LOW : IDLE;
      WAIT_LOW: if (!scores_valid) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the snapshot is small and must read as zero after an aborted scan, so it is reset explicitly.
      for (int k = 0; k < OC; k++) snap[k] <= '0;
      best         <= '0;
      best_idx     <= '0;
      i            <= '0;
      class_idx    <= '0;
      max_score    <= '0;
      result_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (scores_valid) begin
            snap     <= scores;
            best     <= scores[0];
            best_idx <= '0;
            i        <= IDX_W'(1);
            if (OC == 1) begin
              class_idx    <= '0;
              max_score    <= scores[0];
              result_valid <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (take) begin
            best     <= win_val;
            best_idx <= win_idx;
          end
          if (i == LAST_IDX) begin
            class_idx    <= win_idx;
            max_score    <= win_val;
            result_valid <= 1'b1;
          end else begin
            i <= i + 1'b1;
          end
        end
        DONE: begin
          if (result_ack) result_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
